// File: rtl/datapath_mc.sv
// datapath_mc -- multi-cycle LEGv8-style datapath.
//
// Takes one control word per transaction over a valid/ready handshake. ALU,
// STORE and BRANCH words finish on the accept edge. A LOAD holds CW_READY
// low for MEM_LAT cycles and then writes the loaded word into the register
// file.
//
// Ports:
//   CLK, RST           rising-edge clock, synchronous active-high reset
//   CW_VALID/CW_READY  control word handshake (accept = VALID && READY)
//   OP                 00 ALU, 01 LOAD, 10 STORE, 11 BRANCH
//   SA, SB, DA         A-read, B-read and destination register selects
//   WR                 register write enable (ALU op only)
//   FS, C0, M, K       ALU function, carry-in, B-operand select, constant
//   SFL                latch status flags (ALU op only)
//   PC_SEL, COND       branch target select and branch condition
//   PC, PRESTAT        program counter and stored flags {N,Z,C,V}
//   DBG_SEL, DBG_DATA  combinational debug read port into the register file
module datapath_mc #(
  parameter int DW      = 64,
  parameter int NREG    = 32,
  parameter int AW      = 8,
  parameter int PW      = 32,
  parameter int MEM_LAT = 1,
  localparam int SW     = $clog2(NREG)
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          CW_VALID,
  output logic          CW_READY,
  input  logic [1:0]    OP,
  input  logic [SW-1:0] SA,
  input  logic [SW-1:0] SB,
  input  logic [SW-1:0] DA,
  input  logic          WR,
  input  logic [2:0]    FS,
  input  logic          C0,
  input  logic          M,
  input  logic [DW-1:0] K,
  input  logic          SFL,
  input  logic          PC_SEL,
  input  logic [1:0]    COND,
  output logic [PW-1:0] PC,
  output logic [3:0]    PRESTAT,
  input  logic [SW-1:0] DBG_SEL,
  output logic [DW-1:0] DBG_DATA
);

  localparam logic [SW-1:0] XZR       = SW'(NREG - 1);
  localparam logic [1:0]    OP_ALU    = 2'b00;
  localparam logic [1:0]    OP_LOAD   = 2'b01;
  localparam logic [1:0]    OP_STORE  = 2'b10;
  localparam logic [1:0]    OP_BRANCH = 2'b11;
  localparam logic [2:0]    FS_AND    = 3'd0;
  localparam logic [2:0]    FS_OR     = 3'd1;
  localparam logic [2:0]    FS_ADD    = 3'd2;
  localparam logic [2:0]    FS_SUB    = 3'd3;
  localparam logic [2:0]    FS_XOR    = 3'd4;
  localparam logic [2:0]    FS_LSL    = 3'd5;
  localparam logic [2:0]    FS_LSR    = 3'd6;
  localparam logic [2:0]    LAT_INIT  = 3'(MEM_LAT);
  localparam logic [DW-1:0] SHIFT_LIM = DW'(DW);

  typedef enum logic {S_IDLE, S_WAIT} state_t;

  // ---------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------
  state_t        state_reg, state_next;
  logic [2:0]    cnt_reg, cnt_next;
  logic [SW-1:0] ld_dst_reg, ld_dst_next;
  logic [PW-1:0] pc_reg, pc_next;
  logic [3:0]    stat_reg, stat_next;
  logic [DW-1:0] regs_reg [NREG];
  logic [DW-1:0] ram_mem [0:(2**AW)-1];
  logic [DW-1:0] ram_q_reg;

  // ---------------------------------------------------------------------
  // Combinational nets
  // ---------------------------------------------------------------------
  logic          accept;
  logic          ld_done;
  logic [DW-1:0] a_val, b_val, bm_val;
  logic [DW:0]   sum_add, sum_sub;
  logic          shift_zero;
  logic [DW-1:0] alu_f;
  logic          alu_c, alu_v;
  logic [3:0]    alu_flags;
  logic [AW-1:0] ram_addr;
  logic          wb_en;
  logic [SW-1:0] wb_addr;
  logic [DW-1:0] wb_data;
  logic [PW-3:0] k_ext;
  logic [PW-1:0] a_pc;
  logic [PW-1:0] pc_plus4, br_target;
  logic          br_taken;

  // Reset outranks a pending handshake, so nothing is committed on a reset edge.
  assign accept = CW_VALID && CW_READY && !RST;

  // Register reads. XZR is masked here rather than relying on its storage.
  assign a_val    = (SA == XZR) ? '0 : regs_reg[SA];
  assign b_val    = (SB == XZR) ? '0 : regs_reg[SB];
  assign DBG_DATA = (DBG_SEL == XZR) ? '0 : regs_reg[DBG_SEL];
  assign bm_val   = M ? K : b_val;

  // ---------------------------------------------------------------------
  // ALU and flags
  // ---------------------------------------------------------------------
  always_comb begin
    sum_add    = {1'b0, a_val} + {1'b0, bm_val} + {{DW{1'b0}}, C0};
    sum_sub    = {1'b0, a_val} + {1'b0, ~bm_val} + {{DW{1'b0}}, 1'b1};
    // The full operand is compared, so a shift of 64 yields 0 even though
    // only Bm[5:0] drives the shifter.
    shift_zero = (bm_val >= SHIFT_LIM);
    alu_f      = '0;
    alu_c      = 1'b0;
    alu_v      = 1'b0;
    case (FS)
      FS_AND: alu_f = a_val & bm_val;
      FS_OR:  alu_f = a_val | bm_val;
      FS_ADD: begin
        alu_f = sum_add[DW-1:0];
        alu_c = sum_add[DW];
        alu_v = (a_val[DW-1] == bm_val[DW-1]) && (sum_add[DW-1] != a_val[DW-1]);
      end
      FS_SUB: begin
        alu_f = sum_sub[DW-1:0];
        alu_c = sum_sub[DW];
        alu_v = (a_val[DW-1] != bm_val[DW-1]) && (sum_sub[DW-1] != a_val[DW-1]);
      end
      FS_XOR: alu_f = a_val ^ bm_val;
      FS_LSL: alu_f = shift_zero ? '0 : (a_val << bm_val[5:0]);
      FS_LSR: alu_f = shift_zero ? '0 : (a_val >> bm_val[5:0]);
      default: alu_f = bm_val;
    endcase
    alu_flags = {alu_f[DW-1], (alu_f == '0), alu_c, alu_v};
  end

  // RAM addressing uses only the low AW bits of F, so addresses wrap.
  assign ram_addr = alu_f[AW-1:0];

  // ---------------------------------------------------------------------
  // Branch operand widening: K is sign-extended and A is zero-extended
  // whenever PW exceeds DW.
  // ---------------------------------------------------------------------
  for (genvar gi = 0; gi < PW - 2; gi++) begin : g_k_ext
    if (gi < DW) begin : g_in
      assign k_ext[gi] = K[gi];
    end else begin : g_sign
      assign k_ext[gi] = K[DW-1];
    end
  end

  for (genvar gi = 0; gi < PW; gi++) begin : g_a_pc
    if (gi < DW) begin : g_in
      assign a_pc[gi] = a_val[gi];
    end else begin : g_pad
      assign a_pc[gi] = 1'b0;
    end
  end

  // ---------------------------------------------------------------------
  // PC and status register next state
  // ---------------------------------------------------------------------
  always_comb begin
    case (COND)
      2'b00:   br_taken = 1'b1;
      2'b01:   br_taken = stat_reg[2];
      2'b10:   br_taken = !stat_reg[2];
      default: br_taken = stat_reg[3];
    endcase
    pc_plus4  = pc_reg + PW'(4);
    br_target = PC_SEL ? a_pc : (pc_reg + {k_ext, 2'b00});
    pc_next   = pc_reg;
    if (accept) begin
      pc_next = (OP == OP_BRANCH && br_taken) ? br_target : pc_plus4;
    end
    stat_next = stat_reg;
    if (accept && OP == OP_ALU && SFL) begin
      stat_next = alu_flags;
    end
  end

  // ---------------------------------------------------------------------
  // Load sequencing FSM
  // ---------------------------------------------------------------------
  always_comb begin
    state_next  = state_reg;
    cnt_next    = cnt_reg;
    ld_dst_next = ld_dst_reg;
    CW_READY    = 1'b0;
    ld_done     = 1'b0;
    case (state_reg)
      S_IDLE: begin
        CW_READY = 1'b1;
        if (CW_VALID && OP == OP_LOAD) begin
          state_next  = S_WAIT;
          cnt_next    = LAT_INIT;
          ld_dst_next = DA;
        end
      end
      S_WAIT: begin
        cnt_next = cnt_reg - 3'd1;
        // The edge that takes the counter to zero commits the load.
        if (cnt_reg == 3'd1) begin
          ld_done    = 1'b1;
          state_next = S_IDLE;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------
  // Register file write port. Load writeback and ALU writes never coincide
  // because no word is accepted while a load is outstanding.
  // ---------------------------------------------------------------------
  always_comb begin
    wb_en   = 1'b0;
    wb_addr = DA;
    wb_data = alu_f;
    if (ld_done) begin
      wb_en   = (ld_dst_reg != XZR);
      wb_addr = ld_dst_reg;
      wb_data = ram_q_reg;
    end else if (accept && OP == OP_ALU && WR) begin
      wb_en   = (DA != XZR);
      wb_addr = DA;
      wb_data = alu_f;
    end
  end

  // ---------------------------------------------------------------------
  // Sequential state
  // ---------------------------------------------------------------------
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_reg  <= S_IDLE;
      cnt_reg    <= '0;
      ld_dst_reg <= '0;
      pc_reg     <= '0;
      stat_reg   <= '0;
    end else begin
      state_reg  <= state_next;
      cnt_reg    <= cnt_next;
      ld_dst_reg <= ld_dst_next;
      pc_reg     <= pc_next;
      stat_reg   <= stat_next;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int i = 0; i < NREG; i++) begin
        regs_reg[i] <= '0;
      end
    end else if (wb_en) begin
      regs_reg[wb_addr] <= wb_data;
    end
  end

  // Data RAM. It is not cleared by reset. The load word is read once, at the
  // accept edge, into ram_q_reg and held there until the wait counter expires.
  // This keeps the read registered and still lets MEM_LAT=1 complete on the
  // very next edge. A store always precedes a later load by at least one
  // edge, so a load returns the stored data.
  always_ff @(posedge CLK) begin
    if (accept && OP == OP_STORE) begin
      ram_mem[ram_addr] <= b_val;
    end
    if (accept && OP == OP_LOAD) begin
      ram_q_reg <= ram_mem[ram_addr];
    end
  end

  assign PC      = pc_reg;
  assign PRESTAT = stat_reg;

endmodule
